// File: rtl/register_file_mp.sv
// Multi-ported register file with write-first bypass, optional hardwired zero
// register and a per-register pending-writeback scoreboard.
module register_file_mp #(
  parameter int NBITS      = 64,
  parameter int NREGISTERS = 32,
  parameter int NRD        = 2,
  parameter int NWR        = 2,
  parameter int ZERO_REG   = 1,
  localparam int AW        = (NREGISTERS > 1) ? $clog2(NREGISTERS) : 1
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    ENABLE,
  input  logic [NRD-1:0]          RD_EN,
  input  logic [NRD*AW-1:0]       ADD_RD,
  input  logic [NWR-1:0]          WR_EN,
  input  logic [NWR*AW-1:0]       ADD_WR,
  input  logic [NWR*NBITS-1:0]    DATAIN,
  input  logic                    ISSUE_EN,
  input  logic [AW-1:0]           ISSUE_ADD,
  output logic [NRD*NBITS-1:0]    OUT,
  output logic [NRD-1:0]          OUT_VALID,
  output logic [NREGISTERS-1:0]   BUSY
);

  logic [NBITS-1:0]      regs_r     [NREGISTERS];
  logic [NBITS-1:0]      regs_nxt_s [NREGISTERS];
  logic [NREGISTERS-1:0] busy_r;
  logic [NREGISTERS-1:0] busy_nxt_s;
  logic [NRD*NBITS-1:0]  out_r;
  logic [NRD-1:0]        out_valid_r;
  logic [NRD*NBITS-1:0]  rd_data_s;
  logic [AW-1:0]         rd_addr_s;
  logic [NBITS-1:0]      rd_val_s;
  logic [AW-1:0]         wr_addr_s;
  logic                  wr_hit_s;

  // Address names a real, writable register (not out of range, not the zero register)
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (int'(a) < NREGISTERS) && !((ZERO_REG != 0) && (a == {AW{1'b0}}));
  endfunction

  // Next storage and scoreboard state; later write ports override earlier ones, issue overrides clear
  always_comb begin
    for (int r = 0; r < NREGISTERS; r++) begin
      regs_nxt_s[r] = regs_r[r];
    end
    busy_nxt_s = busy_r;
    wr_addr_s  = {AW{1'b0}};
    wr_hit_s   = 1'b0;
    for (int j = 0; j < NWR; j++) begin
      wr_addr_s = ADD_WR[j*AW +: AW];
      wr_hit_s  = ENABLE && WR_EN[j] && addr_ok(wr_addr_s);
      for (int r = 0; r < NREGISTERS; r++) begin
        regs_nxt_s[r] = (wr_hit_s && (wr_addr_s == AW'(r))) ? DATAIN[j*NBITS +: NBITS] : regs_nxt_s[r];
        busy_nxt_s[r] = (wr_hit_s && (wr_addr_s == AW'(r))) ? 1'b0 : busy_nxt_s[r];
      end
    end
    for (int r = 0; r < NREGISTERS; r++) begin
      busy_nxt_s[r] = (ENABLE && ISSUE_EN && (ISSUE_ADD == AW'(r)) && addr_ok(AW'(r))) ? 1'b1 : busy_nxt_s[r];
    end
  end

  // Read data per port: stored value, overridden by same-cycle writes (highest port last)
  always_comb begin
    rd_data_s = {(NRD*NBITS){1'b0}};
    rd_addr_s = {AW{1'b0}};
    rd_val_s  = {NBITS{1'b0}};
    for (int i = 0; i < NRD; i++) begin
      rd_addr_s = ADD_RD[i*AW +: AW];
      rd_val_s  = {NBITS{1'b0}};
      for (int r = 0; r < NREGISTERS; r++) begin
        rd_val_s = (rd_addr_s == AW'(r)) ? regs_r[r] : rd_val_s;
      end
      for (int j = 0; j < NWR; j++) begin
        rd_val_s = (WR_EN[j] && (ADD_WR[j*AW +: AW] == rd_addr_s)) ? DATAIN[j*NBITS +: NBITS] : rd_val_s;
      end
      rd_data_s[i*NBITS +: NBITS] = addr_ok(rd_addr_s) ? rd_val_s : {NBITS{1'b0}};
    end
  end

  // Register storage and scoreboard
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int r = 0; r < NREGISTERS; r++) begin
        regs_r[r] <= {NBITS{1'b0}};
      end
      busy_r <= {NREGISTERS{1'b0}};
    end else begin
      for (int r = 0; r < NREGISTERS; r++) begin
        regs_r[r] <= regs_nxt_s[r];
      end
      busy_r <= busy_nxt_s;
    end
  end

  // Registered read ports; a disabled port reads back zero and invalid
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      out_r       <= {(NRD*NBITS){1'b0}};
      out_valid_r <= {NRD{1'b0}};
    end else if (ENABLE) begin
      for (int i = 0; i < NRD; i++) begin
        out_r[i*NBITS +: NBITS] <= RD_EN[i] ? rd_data_s[i*NBITS +: NBITS] : {NBITS{1'b0}};
      end
      out_valid_r <= RD_EN;
    end else begin
      out_r       <= out_r;
      out_valid_r <= out_valid_r;
    end
  end

  assign OUT       = out_r;
  assign OUT_VALID = out_valid_r;
  assign BUSY      = busy_r;

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp: directed vectors against an array model.
module tb_register_file_mp;

  logic         CLK = 1'b0;
  logic         RESET_N;
  logic         ENABLE;
  logic [1:0]   RD_EN;
  logic [9:0]   ADD_RD;
  logic [1:0]   WR_EN;
  logic [9:0]   ADD_WR;
  logic [127:0] DATAIN;
  logic         ISSUE_EN;
  logic [4:0]   ISSUE_ADD;
  logic [127:0] OUT;
  logic [1:0]   OUT_VALID;
  logic [31:0]  BUSY;

  register_file_mp dut (
    .CLK(CLK), .RESET_N(RESET_N), .ENABLE(ENABLE),
    .RD_EN(RD_EN), .ADD_RD(ADD_RD), .WR_EN(WR_EN), .ADD_WR(ADD_WR),
    .DATAIN(DATAIN), .ISSUE_EN(ISSUE_EN), .ISSUE_ADD(ISSUE_ADD),
    .OUT(OUT), .OUT_VALID(OUT_VALID), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  logic [63:0]  m_regs [32];
  logic [31:0]  m_busy;
  logic [127:0] m_out;
  logic [1:0]   m_valid;
  int checks = 0;
  int failures = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) m_regs[r] = 64'd0;
    m_busy = 32'd0; m_out = 128'd0; m_valid = 2'b00;
  endtask

  // Apply the rules to the inputs about to be clocked: writes in port order, then reads see them
  task automatic model_edge();
    logic [4:0] a;
    if (ENABLE) begin
      for (int j = 0; j < 2; j++) begin
        if (WR_EN[j]) begin
          a = ADD_WR[j*5 +: 5];
          if (a != 5'd0) m_regs[a] = DATAIN[j*64 +: 64];
          m_busy[a] = 1'b0;
        end
      end
      if (ISSUE_EN && ISSUE_ADD != 5'd0) m_busy[ISSUE_ADD] = 1'b1;
      for (int i = 0; i < 2; i++) begin
        a = ADD_RD[i*5 +: 5];
        m_out[i*64 +: 64] = RD_EN[i] ? ((a == 5'd0) ? 64'd0 : m_regs[a]) : 64'd0;
        m_valid[i] = RD_EN[i];
      end
    end
  endtask

  // Compare DUT outputs against the model after every rising edge
  always @(posedge CLK) begin
    #2;
    if (cmp_on) begin
      chk("cyc_out", OUT, m_out);
      chk("cyc_valid", {126'd0, OUT_VALID}, {126'd0, m_valid});
      chk("cyc_busy", {96'd0, BUSY}, {96'd0, m_busy});
    end
  end

  task automatic drive(input logic en, input logic [1:0] rd, input logic [4:0] r0, input logic [4:0] r1,
                       input logic [1:0] wr, input logic [4:0] w0, input logic [63:0] d0,
                       input logic [4:0] w1, input logic [63:0] d1, input logic ie, input logic [4:0] ia);
    ENABLE = en; RD_EN = rd; ADD_RD = {r1, r0}; WR_EN = wr; ADD_WR = {w1, w0};
    DATAIN = {d1, d0}; ISSUE_EN = ie; ISSUE_ADD = ia;
  endtask

  task automatic step();
    model_edge();
    @(posedge CLK);
    #3;
  endtask

  initial begin
    RESET_N = 1'b1;
    drive(1'b0, 2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b0, 5'd0);
    model_reset();
    #1 RESET_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_out", OUT, 128'd0);
    chk("rst_busy", {96'd0, BUSY}, 128'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
    cmp_on = 1'b1;

    // read reg 5 after reset
    drive(1'b1, 2'b01, 5'd5, 5'd0, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b0, 5'd0); step();
    chk("r5_out0", {64'd0, OUT[63:0]}, 128'd0);
    chk("r5_valid", {126'd0, OUT_VALID}, 128'd1);
    chk("r5_busy", {96'd0, BUSY}, 128'd0);

    // write 0xDEAD to reg 7 on port 0, bypass read on port 1
    drive(1'b1, 2'b10, 5'd0, 5'd7, 2'b01, 5'd7, 64'hDEAD, 5'd0, 64'd0, 1'b0, 5'd0); step();
    chk("byp_out1", {64'd0, OUT[127:64]}, 128'hDEAD);
    chk("byp_valid", {126'd0, OUT_VALID}, 128'd2);
    drive(1'b1, 2'b01, 5'd7, 5'd0, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b0, 5'd0); step();
    chk("r7_hold", {64'd0, OUT[63:0]}, 128'hDEAD);

    // both ports write reg 3, port 1 wins
    drive(1'b1, 2'b01, 5'd3, 5'd0, 2'b11, 5'd3, 64'h11, 5'd3, 64'h22, 1'b0, 5'd0); step();
    chk("dual_byp", {64'd0, OUT[63:0]}, 128'h22);
    drive(1'b1, 2'b11, 5'd3, 5'd7, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b0, 5'd0); step();
    chk("dual_store", OUT, {64'hDEAD, 64'h22});

    // zero register: write discarded, bypass returns 0, issue ignored
    drive(1'b1, 2'b11, 5'd0, 5'd0, 2'b10, 5'd0, 64'd0, 5'd0, 64'hFFFF, 1'b1, 5'd0); step();
    chk("z_byp", OUT, 128'd0);
    chk("z_busy", {96'd0, BUSY}, 128'd0);
    drive(1'b1, 2'b01, 5'd0, 5'd0, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b0, 5'd0); step();
    chk("z_read", OUT, 128'd0);

    // scoreboard on reg 9
    drive(1'b1, 2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b1, 5'd9); step();
    chk("sb_set", {96'd0, BUSY}, 128'h200);
    drive(1'b1, 2'b00, 5'd0, 5'd0, 2'b01, 5'd9, 64'h99, 5'd0, 64'd0, 1'b0, 5'd0); step();
    chk("sb_clr", {96'd0, BUSY}, 128'd0);
    drive(1'b1, 2'b00, 5'd0, 5'd0, 2'b10, 5'd0, 64'd0, 5'd9, 64'h98, 1'b1, 5'd9); step();
    chk("sb_issue_wins", {96'd0, BUSY}, 128'h200);

    // ENABLE low: everything holds despite active requests
    drive(1'b1, 2'b11, 5'd9, 5'd3, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b0, 5'd0); step();
    drive(1'b0, 2'b00, 5'd1, 5'd1, 2'b11, 5'd9, 64'h5, 5'd3, 64'h6, 1'b1, 5'd4); step();
    chk("hold_out", OUT, {64'h22, 64'h98});
    chk("hold_busy", {96'd0, BUSY}, 128'h200);

    // mixed traffic on a small address window to force collisions
    for (int n = 0; n < 40; n++) begin
      drive(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), {$urandom, $urandom},
            5'($urandom_range(0, 7)), {$urandom, $urandom}, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
      step();
    end

    // reset in the middle of a burst, between edges, with ENABLE low
    drive(1'b1, 2'b01, 5'd7, 5'd0, 2'b01, 5'd7, 64'hABC, 5'd0, 64'd0, 1'b1, 5'd12); step();
    chk("pre_rst_out", {64'd0, OUT[63:0]}, 128'hABC);
    drive(1'b0, 2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b0, 5'd0); step();
    #1 RESET_N = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_out", OUT, 128'd0);
    chk("mid_rst_valid", {126'd0, OUT_VALID}, 128'd0);
    chk("mid_rst_busy", {96'd0, BUSY}, 128'd0);
    drive(1'b1, 2'b01, 5'd7, 5'd0, 2'b01, 5'd7, 64'h55, 5'd0, 64'd0, 1'b1, 5'd12);
    @(posedge CLK);
    #3 RESET_N = 1'b1;
    drive(1'b1, 2'b11, 5'd7, 5'd12, 2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b0, 5'd0); step();
    chk("post_rst_out", OUT, 128'd0);
    chk("post_rst_valid", {126'd0, OUT_VALID}, 128'd3);
    chk("post_rst_busy", {96'd0, BUSY}, 128'd0);

    cmp_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/register_file_mp.md
REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 SHALL have parameter NBITS, default 64, data width per register.
REQ-002 SHALL have parameter NREGISTERS, default 32, register count; AW = clog2(NREGISTERS).
REQ-003 SHALL have parameter NRD, default 2, number of read ports.
REQ-004 SHALL have parameter NWR, default 2, number of write ports.
REQ-005 SHALL have parameter ZERO_REG, default 1; 1 = register 0 hardwired to zero.
REQ-006 SHALL have port CLK  input  1  single clock; all state changes on rising edge.
REQ-007 SHALL have port RESET_N  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port ENABLE  input  1  global enable for read, write and issue.
REQ-009 SHALL have port RD_EN  input  NRD  per-port read request.
REQ-010 SHALL have port ADD_RD  input  NRD*AW  read addresses; port i at bits [i*AW +: AW].
REQ-011 SHALL have port WR_EN  input  NWR  per-port write request.
REQ-012 SHALL have port ADD_WR  input  NWR*AW  write addresses, packed as ADD_RD.
REQ-013 SHALL have port DATAIN  input  NWR*NBITS  write data; port j at bits [j*NBITS +: NBITS].
REQ-014 SHALL have port ISSUE_EN  input  1  mark destination register pending.
REQ-015 SHALL have port ISSUE_ADD  input  AW  destination register being issued.
REQ-016 SHALL have port OUT  output  NRD*NBITS  registered read data, packed per port.
REQ-017 SHALL have port OUT_VALID  output  NRD  OUT port i holds data captured on the last enabled cycle.
REQ-018 SHALL have port BUSY  output  NREGISTERS  scoreboard, bit r = register r pending writeback.

Function
REQ-019 Read latency SHALL be 1 cycle: at the edge with ENABLE=1, RD_EN[i]=1, OUT[i] takes the value of register ADD_RD[i] and OUT_VALID[i]=1.
REQ-020 At an edge with ENABLE=1, RD_EN[i]=0, OUT[i] SHALL become 0 and OUT_VALID[i] 0.
REQ-021 At an edge with ENABLE=0, OUT, OUT_VALID, registers and BUSY SHALL hold.
REQ-022 Write: at an edge with ENABLE=1, WR_EN[j]=1, register ADD_WR[j] SHALL take DATAIN[j].
REQ-023 Read/write same address same cycle SHALL be write-first: OUT[i] returns the DATAIN being written (bypass).
REQ-024 Multiple write ports to one address same cycle: highest port index SHALL win, for both storage and bypass.
REQ-025 With ZERO_REG=1, writes to address 0 SHALL be discarded, reads of address 0 SHALL return 0 (including bypass), BUSY[0] SHALL stay 0.
REQ-026 Addresses >= NREGISTERS SHALL be ignored on write and SHALL read as 0 with OUT_VALID=1; ISSUE to such address ignored.
REQ-027 ISSUE: at an edge with ENABLE=1, ISSUE_EN=1, BUSY[ISSUE_ADD] SHALL set to 1.
REQ-028 A write with ENABLE=1 to register r SHALL clear BUSY[r] at that edge.
REQ-029 Issue and write to same register same edge: BUSY SHALL end at 1 (issue wins).
REQ-030 BUSY SHALL be a direct register output, no combinational path from inputs.

Reset
REQ-031 RESET_N=0 SHALL immediately, independent of CLK, clear all registers, OUT, OUT_VALID and BUSY to 0.
REQ-032 Reset mid-operation SHALL discard same-cycle writes and issues; first state update on the first rising edge after RESET_N rises.

Verification
REQ-033 Reset then read port 0 of reg 5 with ENABLE=1 -> next cycle OUT[0]=0, OUT_VALID[0]=1, BUSY=0.
REQ-034 Write 0xDEAD to reg 7 via port 0 and read reg 7 on port 1 same edge -> OUT[1]=0xDEAD; reg 7 holds 0xDEAD afterwards.
REQ-035 Ports 0 and 1 write 0x11, 0x22 to reg 3 same edge -> reg 3 = 0x22; bypass read returns 0x22.
REQ-036 Write 0xFFFF to reg 0 (ZERO_REG=1) then read reg 0 -> OUT=0; issue reg 0 -> BUSY[0]=0.
REQ-037 Issue reg 9 -> BUSY[9]=1; later write reg 9 -> BUSY[9]=0; issue+write reg 9 same edge -> BUSY[9]=1.
REQ-038 RESET_N low mid-burst between edges with ENABLE=0 -> outputs 0 before next CLK edge; write presented during reset not stored.
